// File: rtl/ysyx_22041412_skid_buf.sv
// Two-entry valid/ready skid buffer with registered back-pressure and synchronous flush.
// Optional stall counter is built only when YSYX_22041412_SKID_PERF_EN is defined.
module ysyx_22041412_skid_buf #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs come straight from state flops, so no input reaches an output.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // The skid entry is always younger, so it can only advance into main.
                if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops only the valid state; payload registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
        end
    end

`ifdef YSYX_22041412_SKID_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: doc/ysyx_22041412_skid_buf.md
# ysyx_22041412_skid_buf

Two-entry valid/ready pipeline register (skid buffer) placed between adjacent NPC stages, e.g. IF→ID and ID→EX. It sits in place of a plain enable-gated register wherever back-pressure must be registered rather than passed combinationally upstream. It provides full throughput with no combinational path from `out_ready` to `in_ready`, plus a synchronous flush for branch redirect and trap redirect.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits.
- `RESET_VAL`, 0: value of `out_data` and of both storage registers after reset.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream has a payload.
- `in_ready` output 1: buffer can accept; registered.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: buffer holds a payload for downstream; registered.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output WIDTH: head payload; registered.
- `flush` input 1: discard all held and incoming payloads.
- `stall_cnt` output 32: count of back-pressured cycles.

## Operation
- Storage:
  - main register (`main_d`, `main_v`) drives `out_data`/`out_valid`.
  - skid register (`skid_d`, `skid_v`).
- Derived signals:
  - `in_fire = in_valid & in_ready & !flush`
  - `out_fire = out_valid & out_ready`
- States:
  - EMPTY: main_v=0, skid_v=0.
  - BUSY: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
- Output mapping: `in_ready = !skid_v`, `out_valid = main_v`.
- Transitions (`flush=0`):
  - EMPTY: in_fire → BUSY, main_d←in_data.
  - BUSY, in_fire & out_fire → BUSY, main_d←in_data.
  - BUSY, in_fire & !out_fire → FULL, skid_d←in_data; main_d held.
  - BUSY, out_fire & !in_fire → EMPTY.
  - FULL: in_ready=0, so in_fire is impossible. out_fire → BUSY, main_d←skid_d. Otherwise hold.
- Flush: when `flush=1`, the next state is EMPTY regardless of other inputs.
  - Any in_fire is suppressed; the payload is dropped.
  - An out_fire in the same cycle still completes downstream. The downstream stage decides whether to kill it.
  - Data registers are not cleared by flush; only the valid bits are.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- Stability: while `out_valid=1 & out_ready=0`, `out_data` must not change.
- Upstream contract: once asserted, `in_valid`/`in_data` hold until in_fire or flush. The buffer functions correctly even if upstream violates this.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=1`, `out_data=RESET_VAL`
  - `skid_d=RESET_VAL`, `stall_cnt=0`
- Reset priority: rst beats flush and all handshakes. Reset asserted mid-transfer drops both entries the next cycle.
- Latency: in_fire in cycle N → `out_valid=1` with that payload in cycle N+1.
- Throughput: 1 payload/cycle sustained while `out_ready=1`.
- Back-pressure propagation:
  - `out_ready` deasserted at cycle N while BUSY with in_fire → `in_ready=0` from cycle N+1.
  - `out_ready` reasserted at cycle M while FULL → `in_ready=1` from cycle M+1.
- Flush at cycle N → `out_valid=0`, `in_ready=1` in cycle N+1.
- No combinational path from any input to any output.

## Configuration
- Macro `YSYX_22041412_SKID_PERF_EN`.
- Defined:
  - `stall_cnt` increments every cycle with `out_valid=1 & out_ready=0`.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by rst; flush does not clear it.
- Undefined:
  - `stall_cnt` is tied to 32'h0 and no counter flops are built.
  - Handshake behaviour is identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with `in_valid=1` → `out_valid=0`, `in_ready=1`, `out_data=RESET_VAL`, `stall_cnt=0` in the first cycle after release.
- Streaming: `out_ready=1`; send 0x11, 0x22, 0x33 on consecutive cycles → they appear on `out_data` in cycles N+1..N+3 with `out_valid=1`; `in_ready` stays 1.
- Skid fill/drain:
  - Send 0xA then 0xB while `out_ready=0` → FULL, `in_ready=0`, `out_data=0xA` held.
  - Raise `out_ready` → 0xA then 0xB emitted on consecutive cycles; `in_ready=1` one cycle after the first out_fire.
- Flush in FULL, with `in_valid=1` carrying 0xC in the same cycle → next cycle `out_valid=0`, `in_ready=1`; 0xC is never emitted.
- Simultaneous fire in BUSY with main=0x5, `in_data=0x6`, both handshakes firing → 0x5 consumed, `out_data=0x6` next cycle, state stays BUSY.
- Perf counter (macro defined): hold `out_valid=1`, `out_ready=0` for 7 cycles → `stall_cnt=7`. A flush leaves it at 7. Without the macro, `stall_cnt` reads 0.
